// File: rtl/sdrc_port_arbiter_if.sv
// Bundle of the two user ports and the SDRAM controller user interface seen by sdrc_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic's view.
interface sdrc_port_arbiter_if #(
   parameter int ADDR_W = 21,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 8,
   parameter int DQM_W  = 2
);
   logic              sdrc_init_done;
   logic              sdrc_busy_n;
   logic              sdrc_rd_valid;
   logic [DATA_W-1:0] sdrc_rdata;
   logic              sdrc_wr_n;
   logic              sdrc_rd_n;
   logic [ADDR_W-1:0] sdrc_addr;
   logic [LEN_W-1:0]  sdrc_len;
   logic [DATA_W-1:0] sdrc_wdata;
   logic [DQM_W-1:0]  sdrc_dqm;

   logic              p0_req,    p1_req;
   logic              p0_wr,     p1_wr;
   logic [ADDR_W-1:0] p0_addr,   p1_addr;
   logic [LEN_W-1:0]  p0_len,    p1_len;
   logic [DATA_W-1:0] p0_wdata,  p1_wdata;
   logic [DQM_W-1:0]  p0_dqm,    p1_dqm;
   logic              p0_gnt,    p1_gnt;
   logic              p0_wpull,  p1_wpull;
   logic              p0_rvalid, p1_rvalid;
   logic [DATA_W-1:0] p0_rdata,  p1_rdata;
   logic              p0_done,   p1_done;
   logic              arb_err;

   modport slave (
      input  sdrc_init_done, sdrc_busy_n, sdrc_rd_valid, sdrc_rdata,
      input  p0_req, p0_wr, p0_addr, p0_len, p0_wdata, p0_dqm,
      input  p1_req, p1_wr, p1_addr, p1_len, p1_wdata, p1_dqm,
      output sdrc_wr_n, sdrc_rd_n, sdrc_addr, sdrc_len, sdrc_wdata, sdrc_dqm,
      output p0_gnt, p0_wpull, p0_rvalid, p0_rdata, p0_done,
      output p1_gnt, p1_wpull, p1_rvalid, p1_rdata, p1_done,
      output arb_err
   );

   modport master (
      output sdrc_init_done, sdrc_busy_n, sdrc_rd_valid, sdrc_rdata,
      output p0_req, p0_wr, p0_addr, p0_len, p0_wdata, p0_dqm,
      output p1_req, p1_wr, p1_addr, p1_len, p1_wdata, p1_dqm,
      input  sdrc_wr_n, sdrc_rd_n, sdrc_addr, sdrc_len, sdrc_wdata, sdrc_dqm,
      input  p0_gnt, p0_wpull, p0_rvalid, p0_rdata, p0_done,
      input  p1_gnt, p1_wpull, p1_rvalid, p1_rdata, p1_done,
      input  arb_err
   );
endinterface

// File: rtl/sdrc_port_arbiter.sv
// Two-port round-robin arbiter in front of one SDRAM controller; each grant runs a whole burst.
// Optional read-beat watchdog enabled by defining SDRC_ARB_TIMEOUT_EN.
module sdrc_port_arbiter #(
   parameter int ADDR_W  = 21,
   parameter int DATA_W  = 16,
   parameter int LEN_W   = 8,
   parameter int DQM_W   = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                rst_n,
   sdrc_port_arbiter_if.slave  bus
);
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ISSUE    = 3'd1,
      ST_WR_BURST = 3'd2,
      ST_RD_BURST = 3'd3,
      ST_DRAIN    = 3'd4
   } state_e;

   state_e            state_q, state_d;
   logic              owner_q, owner_d;
   logic              wr_q, wr_d;
   logic              ptr_q, ptr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W:0]    cnt_q, cnt_d;
   logic              winner_s;
   logic              done_s;
   logic              err_s;
   logic              issue_s;
   logic              wpull_s;
   logic              rvalid_s;
   logic [DATA_W-1:0] wdata_s;
   logic [DQM_W-1:0]  dqm_s;

`ifdef SDRC_ARB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT) + 1;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
`else
   logic              unused_tmo_s;
   assign unused_tmo_s = (TIMEOUT > 0);
`endif

   // Next-state and burst bookkeeping
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      wr_d     = wr_q;
      ptr_d    = ptr_q;
      addr_d   = addr_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      done_s   = 1'b0;
      err_s    = 1'b0;
      winner_s = (bus.p0_req & bus.p1_req) ? ptr_q : bus.p1_req;
`ifdef SDRC_ARB_TIMEOUT_EN
      tmo_d    = tmo_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.sdrc_init_done & bus.sdrc_busy_n & (bus.p0_req | bus.p1_req)) begin
               state_d = ST_ISSUE;
               owner_d = winner_s;
               wr_d    = winner_s ? bus.p1_wr   : bus.p0_wr;
               addr_d  = winner_s ? bus.p1_addr : bus.p0_addr;
               len_d   = winner_s ? bus.p1_len  : bus.p0_len;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            // Flipping the pointer here is what forces alternation under contention
            ptr_d = ~owner_q;
            cnt_d = wr_q ? {{LEN_W{1'b0}}, 1'b1} : {(LEN_W+1){1'b0}};
`ifdef SDRC_ARB_TIMEOUT_EN
            tmo_d = {TMO_W{1'b0}};
`endif
            if (!wr_q) begin
               state_d = ST_RD_BURST;
            end else if (len_q == {LEN_W{1'b0}}) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_WR_BURST;
            end
         end
         ST_WR_BURST: begin
            if (cnt_q == {1'b0, len_q}) begin
               state_d = ST_DRAIN;
            end else begin
               cnt_d = cnt_q + {{LEN_W{1'b0}}, 1'b1};
            end
         end
         ST_RD_BURST: begin
            if (bus.sdrc_rd_valid) begin
`ifdef SDRC_ARB_TIMEOUT_EN
               tmo_d = {TMO_W{1'b0}};
`endif
               if (cnt_q == {1'b0, len_q}) begin
                  state_d = ST_DRAIN;
               end else begin
                  cnt_d = cnt_q + {{LEN_W{1'b0}}, 1'b1};
               end
            end else begin
`ifdef SDRC_ARB_TIMEOUT_EN
               if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                  err_s   = 1'b1;
                  done_s  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  tmo_d = tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
               end
`else
               state_d = ST_RD_BURST;
`endif
            end
         end
         ST_DRAIN: begin
            if (bus.sdrc_busy_n) begin
               done_s  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and captured request registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         wr_q    <= 1'b0;
         ptr_q   <= 1'b0;
         addr_q  <= {ADDR_W{1'b0}};
         len_q   <= {LEN_W{1'b0}};
         cnt_q   <= {(LEN_W+1){1'b0}};
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         wr_q    <= wr_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef SDRC_ARB_TIMEOUT_EN
   // Read-beat watchdog counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmo_q <= {TMO_W{1'b0}};
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   assign issue_s  = (state_q == ST_ISSUE);
   assign wpull_s  = (issue_s & wr_q) | (state_q == ST_WR_BURST);
   assign rvalid_s = (state_q == ST_RD_BURST) & bus.sdrc_rd_valid;
   assign wdata_s  = owner_q ? bus.p1_wdata : bus.p0_wdata;
   assign dqm_s    = owner_q ? bus.p1_dqm   : bus.p0_dqm;

   assign bus.sdrc_wr_n  = ~(issue_s & wr_q);
   assign bus.sdrc_rd_n  = ~(issue_s & ~wr_q);
   assign bus.sdrc_addr  = addr_q;
   assign bus.sdrc_len   = len_q;
   assign bus.sdrc_wdata = wdata_s;
   assign bus.sdrc_dqm   = dqm_s;

   assign bus.p0_gnt    = issue_s  & ~owner_q;
   assign bus.p1_gnt    = issue_s  &  owner_q;
   assign bus.p0_wpull  = wpull_s  & ~owner_q;
   assign bus.p1_wpull  = wpull_s  &  owner_q;
   assign bus.p0_rvalid = rvalid_s & ~owner_q;
   assign bus.p1_rvalid = rvalid_s &  owner_q;
   assign bus.p0_rdata  = bus.sdrc_rdata;
   assign bus.p1_rdata  = bus.sdrc_rdata;
   assign bus.p0_done   = done_s   & ~owner_q;
   assign bus.p1_done   = done_s   &  owner_q;
   assign bus.arb_err   = err_s;
endmodule

// File: tb/tb_sdrc_port_arbiter.sv
// Directed bench for sdrc_port_arbiter with a small behavioural SDRAM controller responder.
// Watchdog scenario runs only when SDRC_ARB_TIMEOUT_EN is defined (TIMEOUT overridden to 16).
module tb_sdrc_port_arbiter;
   localparam int ADDR_W = 21, DATA_W = 16, LEN_W = 8, DQM_W = 2, TIMEOUT = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sdrc_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .DQM_W(DQM_W)) bus();

   sdrc_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .DQM_W(DQM_W),
                       .TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_checks = 0, n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Write data = beat index (port 0) or 0x100 + beat index (port 1)
   logic [15:0] p0_wbeat = 16'd0, p1_wbeat = 16'd0;
   assign bus.p0_wdata = bus.p0_gnt ? 16'h0000 : p0_wbeat;
   assign bus.p1_wdata = bus.p1_gnt ? 16'h0100 : (16'h0100 + p1_wbeat);
   assign bus.p0_dqm   = 2'b00;
   assign bus.p1_dqm   = 2'b00;
   always @(posedge clk) begin
      if (bus.p0_wpull) p0_wbeat <= bus.p0_gnt ? 16'd1 : p0_wbeat + 16'd1;
      if (bus.p1_wpull) p1_wbeat <= bus.p1_gnt ? 16'd1 : p1_wbeat + 16'd1;
   end

   // Controller responder: busy after each strobe, read beats after 4 cycles
   logic [15:0] mem [0:1023];
   logic [9:0]  wr_ptr, rd_ptr;
   int          busy_cnt, rd_left, rd_dly, rd_sent;
   int          rd_limit = 1000;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.sdrc_busy_n   <= 1'b1;
         bus.sdrc_rd_valid <= 1'b0;
         bus.sdrc_rdata    <= 16'h0000;
         busy_cnt <= 0; rd_left <= 0; rd_dly <= 0; rd_sent <= 0;
         wr_ptr <= 10'd0; rd_ptr <= 10'd0;
      end else begin
         bus.sdrc_rd_valid <= 1'b0;
         if (!bus.sdrc_wr_n || !bus.sdrc_rd_n) begin
            bus.sdrc_busy_n <= 1'b0;
            busy_cnt <= int'(bus.sdrc_len) + 8;
         end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) bus.sdrc_busy_n <= 1'b1;
         end
         if (!bus.sdrc_wr_n) begin
            mem[bus.sdrc_addr[9:0]] <= bus.sdrc_wdata;
            wr_ptr <= bus.sdrc_addr[9:0] + 10'd1;
         end else if (bus.p0_wpull || bus.p1_wpull) begin
            mem[wr_ptr] <= bus.sdrc_wdata;
            wr_ptr <= wr_ptr + 10'd1;
         end
         if (!bus.sdrc_rd_n) begin
            rd_left <= int'(bus.sdrc_len) + 1; rd_ptr <= bus.sdrc_addr[9:0];
            rd_dly <= 3; rd_sent <= 0;
         end else if (rd_dly != 0) begin
            rd_dly <= rd_dly - 1;
         end else if (rd_left != 0) begin
            if (rd_sent < rd_limit) begin
               bus.sdrc_rd_valid <= 1'b1;
               bus.sdrc_rdata <= mem[rd_ptr];
               rd_ptr <= rd_ptr + 10'd1; rd_sent <= rd_sent + 1; rd_left <= rd_left - 1;
            end else begin
               rd_left <= 0;
            end
         end
      end
   end

   // Monitor, sampled on the falling edge
   int cyc = 0, n_strobe = 0, n_strobe_busy = 0, strobe_cyc = 0;
   int n_gnt0 = 0, n_gnt1 = 0, n_wp0 = 0, n_wp1 = 0, wp0_mark = 0, wp0_first = 0, wp0_last = 0;
   int n_rv0 = 0, n_rv1 = 0, rv0_k = 0, rv1_k = 0, last_rv_cyc = 0;
   int n_done0 = 0, n_done1 = 0, done0_cyc = 0, n_err = 0, err_cyc = 0;
   logic [31:0] strobe_addr = 32'd0, strobe_len = 32'd0, exp_base0 = 32'd0, exp_base1 = 32'd0;
   int gnt_q[$];
   always @(negedge clk) begin
      cyc++;
      if (!bus.sdrc_wr_n || !bus.sdrc_rd_n) begin
         n_strobe++;
         if (!bus.sdrc_busy_n) n_strobe_busy++;
         strobe_cyc = cyc; strobe_addr = 32'(bus.sdrc_addr); strobe_len = 32'(bus.sdrc_len);
      end
      if (bus.p0_gnt) begin gnt_q.push_back(0); n_gnt0++; rv0_k = 0; end
      if (bus.p1_gnt) begin gnt_q.push_back(1); n_gnt1++; rv1_k = 0; end
      if (bus.p0_wpull) begin
         if (n_wp0 == wp0_mark) wp0_first = cyc;
         n_wp0++; wp0_last = cyc;
      end
      if (bus.p1_wpull) n_wp1++;
      if (bus.p0_rvalid) begin
         check_eq("p0_rdata", 32'(bus.p0_rdata), exp_base0 + 32'(rv0_k));
         rv0_k++; n_rv0++; last_rv_cyc = cyc;
      end
      if (bus.p1_rvalid) begin
         check_eq("p1_rdata", 32'(bus.p1_rdata), exp_base1 + 32'(rv1_k));
         rv1_k++; n_rv1++; last_rv_cyc = cyc;
      end
      if (bus.p0_done) begin n_done0++; done0_cyc = cyc; end
      if (bus.p1_done) n_done1++;
      if (bus.arb_err) begin n_err++; err_cyc = cyc; end
   end

   task automatic set_req(input int port, input logic wr, input logic [20:0] addr,
                          input logic [7:0] len, input logic req);
      if (port == 0) begin
         bus.p0_wr = wr; bus.p0_addr = addr; bus.p0_len = len; bus.p0_req = req;
      end else begin
         bus.p1_wr = wr; bus.p1_addr = addr; bus.p1_len = len; bus.p1_req = req;
      end
   endtask

   task automatic run_burst(input int port, input logic wr, input logic [20:0] addr,
                            input logic [7:0] len);
      bit got;
      got = 1'b0;
      set_req(port, wr, addr, len, 1'b1);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if ((port == 0) ? bus.p0_gnt : bus.p1_gnt) begin got = 1'b1; break; end
      end
      set_req(port, wr, addr, len, 1'b0);
      check_eq("gnt_seen", 32'(got), 32'd1);
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if ((port == 0) ? bus.p0_done : bus.p1_done) begin got = 1'b1; break; end
      end
      check_eq("done_seen", 32'(got), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   int s0, s1, s2, s3, s4;
   bit got;
   initial begin
      bus.sdrc_init_done = 1'b0;
      set_req(0, 1'b0, 21'd0, 8'd0, 1'b0);
      set_req(1, 1'b0, 21'd0, 8'd0, 1'b0);
      repeat (3) @(negedge clk);
      check_eq("rst_wr_n", 32'(bus.sdrc_wr_n), 32'd1);
      check_eq("rst_rd_n", 32'(bus.sdrc_rd_n), 32'd1);
      check_eq("rst_addr", 32'(bus.sdrc_addr), 32'd0);
      check_eq("rst_len", 32'(bus.sdrc_len), 32'd0);
      check_eq("rst_pN", 32'({bus.p0_gnt, bus.p1_gnt, bus.p0_wpull, bus.p1_wpull,
                              bus.p0_done, bus.p1_done, bus.arb_err}), 32'd0);
      rst_n = 1'b1;

      // Request before init_done must wait
      set_req(0, 1'b1, 21'h040005, 8'd10, 1'b1);
      repeat (20) @(negedge clk);
      check_eq("no_strobe_pre_init", 32'(n_strobe), 32'd0);
      bus.sdrc_init_done = 1'b1;

      // 1: p0 write len 10
      s0 = n_strobe; s1 = n_wp0; s2 = n_done0; s3 = n_wp1; wp0_mark = n_wp0;
      run_burst(0, 1'b1, 21'h040005, 8'd10);
      check_eq("t1_strobes", 32'(n_strobe - s0), 32'd1);
      check_eq("t1_addr", strobe_addr, 32'h040005);
      check_eq("t1_len", strobe_len, 32'd10);
      check_eq("t1_wpull", 32'(n_wp0 - s1), 32'd11);
      check_eq("t1_wpull_contig", 32'(wp0_last - wp0_first + 1), 32'd11);
      check_eq("t1_wpull_at_strobe", 32'(wp0_first), 32'(strobe_cyc));
      check_eq("t1_done", 32'(n_done0 - s2), 32'd1);
      check_eq("t1_p1_wpull", 32'(n_wp1 - s3), 32'd0);

      // 2: p0 read back the same burst
      exp_base0 = 32'd0; s0 = n_rv0; s1 = n_rv1; s2 = n_done0;
      run_burst(0, 1'b0, 21'h040005, 8'd10);
      check_eq("t2_rvalid0", 32'(n_rv0 - s0), 32'd11);
      check_eq("t2_rvalid1", 32'(n_rv1 - s1), 32'd0);
      check_eq("t2_done", 32'(n_done0 - s2), 32'd1);

      // 4: len=0 write and read on p1 (also leaves the pointer at port 0)
      s0 = n_wp1; s1 = n_done1;
      run_burst(1, 1'b1, 21'h000100, 8'd0);
      check_eq("t4_wpull1", 32'(n_wp1 - s0), 32'd1);
      check_eq("t4_wr_done", 32'(n_done1 - s1), 32'd1);
      exp_base1 = 32'h100; s0 = n_rv1; s1 = n_rv0; s2 = n_done1;
      run_burst(1, 1'b0, 21'h000100, 8'd0);
      check_eq("t4_rvalid1", 32'(n_rv1 - s0), 32'd1);
      check_eq("t4_rvalid0", 32'(n_rv0 - s1), 32'd0);
      check_eq("t4_rd_done", 32'(n_done1 - s2), 32'd1);

      // 3: contention, both requests held
      gnt_q.delete(); s0 = n_strobe_busy;
      set_req(0, 1'b1, 21'h000200, 8'd2, 1'b1);
      set_req(1, 1'b1, 21'h000300, 8'd2, 1'b1);
      got = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (gnt_q.size() >= 4) begin got = 1'b1; break; end
      end
      set_req(0, 1'b1, 21'h000200, 8'd2, 1'b0);
      set_req(1, 1'b1, 21'h000300, 8'd2, 1'b0);
      repeat (60) @(negedge clk);
      check_eq("t3_four_grants", 32'(got), 32'd1);
      check_eq("t3_grant_total", 32'(gnt_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < gnt_q.size(); i++)
         check_eq("t3_grant_order", 32'(gnt_q[i]), 32'(i % 2));
      check_eq("t3_strobe_while_busy", 32'(n_strobe_busy - s0), 32'd0);

      // 5: reset during write beat 5
      s0 = n_done0; s1 = 0; got = 1'b0;
      set_req(0, 1'b1, 21'h040005, 8'd10, 1'b1);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.p0_gnt) set_req(0, 1'b1, 21'h040005, 8'd10, 1'b0);
         if (bus.p0_wpull) s1++;
         if (s1 == 6) begin got = 1'b1; break; end
      end
      check_eq("t5_reached_beat5", 32'(got), 32'd1);
      rst_n = 1'b0;
      #1;
      check_eq("t5_wr_n", 32'(bus.sdrc_wr_n), 32'd1);
      check_eq("t5_wpull", 32'(bus.p0_wpull), 32'd0);
      check_eq("t5_addr", 32'(bus.sdrc_addr), 32'd0);
      check_eq("t5_len", 32'(bus.sdrc_len), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      s2 = n_gnt1;
      run_burst(1, 1'b1, 21'h000140, 8'd3);
      check_eq("t5_next_grant", 32'(n_gnt1 - s2), 32'd1);
      check_eq("t5_no_done_on_reset", 32'(n_done0 - s0), 32'd0);

`ifdef SDRC_ARB_TIMEOUT_EN
      // 6: read with only 4 beats returned
      rd_limit = 4; s0 = n_err; s1 = n_rv0; exp_base0 = 32'd0;
      run_burst(0, 1'b0, 21'h040005, 8'd10);
      rd_limit = 1000;
      check_eq("t6_beats", 32'(n_rv0 - s1), 32'd4);
      check_eq("t6_err", 32'(n_err - s0), 32'd1);
      check_eq("t6_err_delay", 32'(err_cyc - last_rv_cyc), 32'd16);
      check_eq("t6_done_with_err", 32'(done0_cyc), 32'(err_cyc));
      s2 = n_gnt1;
      run_burst(1, 1'b1, 21'h000180, 8'd0);
      check_eq("t6_next_grant", 32'(n_gnt1 - s2), 32'd1);
`else
      check_eq("arb_err_never", 32'(n_err), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
